// File: rtl/sd_spi_cmd.sv
// SD card SPI command engine.
// Sends the 6-byte command frame (with CRC7), then polls for the R1 response.
// Frame per command: one FF preamble, six command bytes, 1..RESP_TIMEOUT poll
// bytes and one FF trailer, all back to back in SPI mode 0.
module sd_spi_cmd #(
    parameter int CLK_DIV      = 4,
    parameter int RESP_TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_start,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_arg,
    input  logic        hold_cs,
    output logic        busy,
    output logic        done,
    output logic [7:0]  r1,
    output logic        timeout,
    output logic        sdCS,
    output logic        sdSCLK,
    output logic        sdMOSI,
    input  logic        sdMISO
);

    localparam int PH_W = $clog2(2 * CLK_DIV);

    typedef enum logic [2:0] {IDLE, PRE, SEND, POLL, POST, DONE} state_t;

    state_t           state, state_n;
    logic [PH_W-1:0]  ph;
    logic [2:0]       bit_cnt;
    logic [2:0]       byte_cnt;
    logic [7:0]       poll_cnt;
    logic [7:0]       tx;
    logic [7:0]       rx;
    logic [5:0]       idx_q;
    logic [31:0]      arg_q;
    logic             hold_q;

    logic             active;
    logic             rise;
    logic             cell_end;
    logic             byte_end;
    logic             resp_ok;
    logic             poll_last;
    logic [2:0]       cmd_sel;
    logic [7:0]       next_byte;
    logic [6:0]       crc;
    logic [47:0]      frame;

    // CRC7 (x^7 + x^3 + 1), MSB first, zero initial value
    function automatic logic [6:0] crc7(input logic [39:0] data);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int unsigned i = 0; i < 40; i++) begin
            fb = c[6] ^ data[39-i];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    assign crc   = crc7({2'b01, idx_q, arg_q});
    assign frame = {2'b01, idx_q, arg_q, crc, 1'b1};

    // Sequencing strobes, next-state decision and the byte to load next
    always_comb begin
        state_n   = state;
        next_byte = 8'hFF;
        active    = (state == PRE) || (state == SEND) || (state == POLL) || (state == POST);
        rise      = active && (ph == PH_W'(CLK_DIV - 1));
        cell_end  = active && (ph == PH_W'(2 * CLK_DIV - 1));
        byte_end  = cell_end && (bit_cnt == 3'd7);
        resp_ok   = ~rx[7];
        poll_last = (poll_cnt == 8'(RESP_TIMEOUT - 1));
        cmd_sel   = (state == PRE) ? 3'd0 : byte_cnt + 3'd1;
        busy      = active;
        done      = (state == DONE);

        if ((state == PRE) || ((state == SEND) && (byte_cnt != 3'd5))) begin
            case (cmd_sel)
                3'd0:    next_byte = frame[47:40];
                3'd1:    next_byte = frame[39:32];
                3'd2:    next_byte = frame[31:24];
                3'd3:    next_byte = frame[23:16];
                3'd4:    next_byte = frame[15:8];
                default: next_byte = frame[7:0];
            endcase
        end

        case (state)
            IDLE: if (cmd_start) state_n = PRE;
            PRE:  if (byte_end) state_n = SEND;
            SEND: if (byte_end && (byte_cnt == 3'd5)) state_n = POLL;
            POLL: if (byte_end && (resp_ok || poll_last)) state_n = POST;
            POST: if (byte_end) state_n = DONE;
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Bit-cell timing, shifting, response capture and pin registers
    always_ff @(posedge clk) begin
        if (reset) begin
            sdCS     <= 1'b1;
            sdSCLK   <= 1'b0;
            sdMOSI   <= 1'b1;
            r1       <= 8'hFF;
            timeout  <= 1'b0;
            ph       <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            poll_cnt <= '0;
            tx       <= '1;
            rx       <= '1;
            idx_q    <= '0;
            arg_q    <= '0;
            hold_q   <= 1'b0;
        end else if (state == IDLE) begin
            if (cmd_start) begin
                idx_q    <= cmd_index;
                arg_q    <= cmd_arg;
                hold_q   <= hold_cs;
                timeout  <= 1'b0;
                sdCS     <= 1'b0;
                sdSCLK   <= 1'b0;
                sdMOSI   <= 1'b1;
                tx       <= 8'hFF;
                ph       <= '0;
                bit_cnt  <= '0;
                byte_cnt <= '0;
                poll_cnt <= '0;
            end
        end else if (active) begin
            ph <= cell_end ? '0 : ph + PH_W'(1);
            if (rise) begin
                sdSCLK <= 1'b1;
                rx     <= {rx[6:0], sdMISO};
            end
            if (cell_end) begin
                sdSCLK  <= 1'b0;
                bit_cnt <= bit_cnt + 3'd1;
                if (!byte_end) begin
                    tx     <= {tx[6:0], 1'b0};
                    sdMOSI <= tx[6];
                end else begin
                    tx     <= next_byte;
                    sdMOSI <= next_byte[7];
                    case (state)
                        SEND: if (byte_cnt != 3'd5) byte_cnt <= byte_cnt + 3'd1;
                        POLL: begin
                            poll_cnt <= poll_cnt + 8'd1;
                            if (resp_ok) begin
                                r1 <= rx;
                            end else if (poll_last) begin
                                r1      <= 8'hFF;
                                timeout <= 1'b1;
                            end
                        end
                        POST: if (!hold_q) sdCS <= 1'b1;
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_sd_spi_cmd.sv
// Bench for sd_spi_cmd: an SD-card pin model answers polls, and a timing
// model derived from frame/byte arithmetic predicts every pin each cycle.
module tb_sd_spi_cmd;

    localparam int CD = 4;
    localparam int RT = 8;
    localparam int BT = 16 * CD;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_start = 1'b0;
    logic [5:0]  cmd_index = '0;
    logic [31:0] cmd_arg = '0;
    logic        hold_cs = 1'b0;
    logic        busy, done, timeout, sdCS, sdSCLK, sdMOSI;
    logic [7:0]  r1;
    logic        sdMISO = 1'b1;

    sd_spi_cmd #(.CLK_DIV(CD), .RESP_TIMEOUT(RT)) dut (
        .clk(clk), .reset(reset), .cmd_start(cmd_start), .cmd_index(cmd_index),
        .cmd_arg(cmd_arg), .hold_cs(hold_cs), .busy(busy), .done(done), .r1(r1),
        .timeout(timeout), .sdCS(sdCS), .sdSCLK(sdSCLK), .sdMOSI(sdMOSI), .sdMISO(sdMISO)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // command model
    bit         cmd_live = 1'b0;
    int         acc, total, m_k, m_falls, m_rises, done_e;
    bit         m_hold, m_found;
    logic [7:0] m_resp;
    logic [7:0] fb [6];
    logic [7:0] cap [32];
    logic [7:0] exp_r1 = 8'hFF;
    logic       exp_to = 1'b0;
    logic       idle_cs = 1'b1;
    logic       prev_sclk = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // CRC7 as polynomial long division of data*x^7 by x^7+x^3+1
    function automatic logic [6:0] model_crc(input logic [39:0] d);
        logic [46:0] r;
        r = {d, 7'b0};
        for (int i = 46; i >= 7; i--)
            if (r[i]) r = r ^ (47'h89 << (i - 7));
        return r[6:0];
    endfunction

    // bit n of the MOSI stream: byte 0 preamble, 1..6 command, rest FF
    function automatic logic mosi_bit(input int n);
        int b;
        b = n / 8;
        if (b >= 1 && b <= 6) return fb[b-1][7 - n % 8];
        return 1'b1;
    endfunction

    // card answers on poll byte k, which is stream byte 6+k
    function automatic logic miso_bit(input int n);
        int b;
        b = n / 8;
        if (m_found && b == 6 + m_k) return m_resp[7 - n % 8];
        return 1'b1;
    endfunction

    // per-cycle check of all outputs plus the card pin model
    always @(negedge clk) begin
        int e;
        if (!reset) begin
            e = cyc - acc;
            if (cmd_live && e >= 1) begin
                if (!prev_sclk && sdSCLK) begin
                    if (m_rises / 8 < 32) cap[m_rises / 8][7 - m_rises % 8] = sdMOSI;
                    m_rises++;
                end
                if (prev_sclk && !sdSCLK) begin
                    m_falls++;
                    sdMISO = miso_bit(m_falls);
                end
                if (done) done_e = e;
            end
            if (!cmd_live || e == 0) begin
                chk("idle_busy", busy, 0);
                chk("idle_done", done, 0);
                chk("idle_sclk", sdSCLK, 0);
                chk("idle_mosi", sdMOSI, 1);
                chk("idle_cs", sdCS, idle_cs);
                chk("idle_r1", r1, exp_r1);
                chk("idle_timeout", timeout, exp_to);
            end else if (e <= total) begin
                chk("busy", busy, 1);
                chk("done_early", done, 0);
                chk("cs_active", sdCS, 0);
                chk("sclk", sdSCLK, (((e - 1) % (2 * CD)) >= CD) ? 1 : 0);
                chk("mosi", sdMOSI, mosi_bit((e - 1) / (2 * CD)));
            end else begin
                exp_r1 = m_found ? m_resp : 8'hFF;
                exp_to = !m_found;
                idle_cs = m_hold ? 1'b0 : 1'b1;
                chk("done_pulse", done, 1);
                chk("done_busy", busy, 0);
                chk("done_cs", sdCS, idle_cs);
                chk("done_sclk", sdSCLK, 0);
                chk("done_mosi", sdMOSI, 1);
                chk("done_r1", r1, exp_r1);
                chk("done_timeout", timeout, exp_to);
                cmd_live = 1'b0;
                sdMISO = 1'b1;
            end
        end
        prev_sclk = sdSCLK;
    end

    task automatic reset_checks(input string tag);
        chk({tag, "_cs"}, sdCS, 1);
        chk({tag, "_sclk"}, sdSCLK, 0);
        chk({tag, "_mosi"}, sdMOSI, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_r1"}, r1, 8'hFF);
        chk({tag, "_timeout"}, timeout, 0);
    endtask

    task automatic launch(input logic [5:0] idx, input logic [31:0] arg, input bit hold,
                          input int k, input logic [7:0] resp, input bit pulse, input int abort_e);
        int n;
        @(posedge clk); #1;
        fb[0] = {2'b01, idx};
        fb[1] = arg[31:24];
        fb[2] = arg[23:16];
        fb[3] = arg[15:8];
        fb[4] = arg[7:0];
        fb[5] = {model_crc({2'b01, idx, arg}), 1'b1};
        m_hold  = hold;
        m_k     = k;
        m_found = (k >= 1 && k <= RT);
        m_resp  = resp;
        total   = (8 + (m_found ? k : RT)) * BT;
        m_falls = 0;
        m_rises = 0;
        done_e  = -1;
        for (int i = 0; i < 32; i++) cap[i] = 8'h00;
        sdMISO    = 1'b1;
        acc       = cyc;
        cmd_live  = 1'b1;
        cmd_start = 1'b1;
        cmd_index = idx;
        cmd_arg   = arg;
        hold_cs   = hold;
        @(posedge clk); #1;
        cmd_start = 1'b0;
        cmd_index = 6'($urandom);
        cmd_arg   = $urandom;
        hold_cs   = 1'($urandom);
        n = 0;
        while (cmd_live && n < total + 50) begin
            @(posedge clk); #1;
            n++;
            if (pulse && (cyc - acc) < total - 2) begin
                cmd_start = 1'($urandom_range(0, 1));
                cmd_index = 6'($urandom);
                cmd_arg   = $urandom;
                hold_cs   = 1'($urandom);
            end else begin
                cmd_start = 1'b0;
            end
            if (abort_e > 0 && (cyc - acc) == abort_e) begin
                reset = 1'b1;
                cmd_start = 1'b0;
                @(negedge clk);
                chk("abort_no_done", done, 0);
                @(negedge clk);
                reset_checks("abort");
                cmd_live = 1'b0;
                idle_cs  = 1'b1;
                exp_r1   = 8'hFF;
                exp_to   = 1'b0;
                sdMISO   = 1'b1;
                @(posedge clk); #1;
                reset = 1'b0;
                return;
            end
        end
        cmd_start = 1'b0;
        if (cmd_live) begin
            checks++;
            errors++;
            $display("FAIL done_wait: got no done, required done within %0d cycles", total + 50);
            cmd_live = 1'b0;
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_checks("reset");
        @(posedge clk); #1;
        reset = 1'b0;

        chk("model_crc_cmd0", model_crc(40'h40_0000_0000), 7'h4A);
        chk("model_crc_cmd8", model_crc(40'h48_0000_01AA), 7'h43);

        // CMD0, R1=01 on poll byte 2
        launch(6'd0, 32'h0, 1'b0, 2, 8'h01, 1'b0, 0);
        chk("cmd0_done_cycle", done_e, 641);
        chk("cmd0_byte0", cap[0], 8'hFF);
        chk("cmd0_byte1", cap[1], 8'h40);
        chk("cmd0_crc", cap[6], 8'h95);
        chk("cmd0_trailer", cap[9], 8'hFF);
        chk("cmd0_r1", r1, 8'h01);
        chk("cmd0_timeout", timeout, 0);
        chk("cmd0_cs", sdCS, 1);

        // CMD8, R1 on first poll byte
        launch(6'd8, 32'h0000_01AA, 1'b0, 1, 8'h01, 1'b0, 0);
        chk("cmd8_done_cycle", done_e, 577);
        chk("cmd8_byte1", cap[1], 8'h48);
        chk("cmd8_byte4", cap[4], 8'h01);
        chk("cmd8_byte5", cap[5], 8'hAA);
        chk("cmd8_crc", cap[6], 8'h87);

        // MISO stuck high
        launch(6'($urandom), $urandom, 1'b0, 0, 8'h00, 1'b0, 0);
        chk("to_done_cycle", done_e, 1025);
        chk("to_trailer", cap[15], 8'hFF);
        chk("to_r1", r1, 8'hFF);
        chk("to_timeout", timeout, 1);

        // cmd_start hammered while busy, then a normal command
        launch(6'($urandom), $urandom, 1'b0, 3, 8'($urandom) & 8'h7F, 1'b1, 0);
        chk("pulse_done_cycle", done_e, 1 + 11 * BT);
        launch(6'd55, 32'h0, 1'b0, 1, 8'h00, 1'b0, 0);
        chk("after_pulse_r1", r1, 8'h00);

        // hold_cs across two commands
        launch(6'd17, $urandom, 1'b1, $urandom_range(1, RT), 8'($urandom) & 8'h7F, 1'b0, 0);
        repeat ($urandom_range(2, 10)) @(posedge clk);
        @(negedge clk);
        chk("hold_idle_cs", sdCS, 0);
        chk("hold_idle_sclk", sdSCLK, 0);
        launch(6'd18, $urandom, 1'b0, $urandom_range(1, RT), 8'($urandom) & 8'h7F, 1'b0, 0);
        chk("hold_release_cs", sdCS, 1);

        // reset in the middle of command byte 3
        launch(6'd24, $urandom, 1'b0, 2, 8'h01, 1'b0, 1 + 4 * BT + BT / 2);
        repeat (3) @(posedge clk);
        launch(6'd0, 32'h0, 1'b0, 2, 8'h01, 1'b0, 0);
        chk("post_reset_done_cycle", done_e, 641);
        chk("post_reset_crc", cap[6], 8'h95);

        // random commands
        for (int t = 0; t < 12; t++) begin
            launch(6'($urandom), $urandom, 1'($urandom), $urandom_range(0, RT + 1),
                   8'($urandom) & 8'h7F, 1'($urandom), 0);
            repeat ($urandom_range(0, 5)) @(posedge clk);
        end

        repeat (4) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sd_spi_cmd.md
# sd_spi_cmd

SPI command engine between the RK05 disk emulation (IOT 674x handler) and the SD card pins sdCS/sdSCLK/sdMOSI/sdMISO. It accepts a command index and 32-bit argument, builds the 6-byte SD command frame with CRC7, and polls for the R1 response byte. It returns R1 or a timeout flag. The sdsim bench model sits directly on its pins.

## Interface
- CLK_DIV, 4: clk cycles per SCLK half-period; must be ≥2.
- RESP_TIMEOUT, 8: maximum poll bytes while waiting for R1; 1..255.

- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cmd_start  in  1  single-cycle request; sampled only in IDLE.
- cmd_index  in  6  SD command number; latched on accept.
- cmd_arg  in  32  command argument, MSB first; latched on accept.
- hold_cs  in  1  latched on accept; 1 = leave sdCS low after done, for a following data phase.
- busy  out  1  high from the cycle after accept until done.
- done  out  1  one-cycle pulse at completion.
- r1  out  8  last R1 byte; holds until the next accept.
- timeout  out  1  set with done if no R1 was received; holds until the next accept.
- sdCS  out  1  active-low chip select.
- sdSCLK  out  1  SPI clock, mode 0, idles low.
- sdMOSI  out  1  serial data out; idles high.
- sdMISO  in  1  serial data in.

## Operation
- Reset values: busy=0, done=0, r1=8'hFF, timeout=0, sdCS=1, sdSCLK=0, sdMOSI=1; state IDLE.
- States: IDLE → PRE → SEND → POLL → POST → DONE → IDLE.
- IDLE: on cmd_start=1, latch the inputs, clear timeout, go to PRE. cmd_start in any other state is ignored (no queueing).
- PRE: drive sdCS low and shift one 8'hFF byte.
- SEND: shift 6 bytes, MSB first:
  - byte 0: {2'b01, cmd_index};
  - bytes 1–4: cmd_arg[31:24] down to cmd_arg[7:0];
  - byte 5: {crc7, 1'b1}.
- CRC7: polynomial x^7+x^3+1, initial value 0, computed over bytes 0–4.
- POLL: shift 8'hFF and capture MISO into a shift register.
  - If a captured byte has bit7=0: r1 ← byte, go to POST.
  - If RESP_TIMEOUT bytes arrive with bit7=1: r1 ← 8'hFF, timeout ← 1, go to POST.
- POST: shift one 8'hFF trailer byte. At its end, sdCS ← 1 unless hold_cs was latched as 1.
- DONE: done=1 for one cycle, busy=0 in that same cycle, then return to IDLE.
- When hold_cs=1, sdCS stays low in IDLE until the next accepted command with hold_cs=0 completes, or until reset.

## Timing
- Bit cell is 2×CLK_DIV cycles:
  - first CLK_DIV cycles: SCLK low, MOSI stable (updated on the cycle SCLK falls or the bit cell starts);
  - next CLK_DIV cycles: SCLK high.
- MISO is sampled in the clk cycle where sdSCLK goes 0→1.
- Byte time is 16×CLK_DIV cycles. There are no gaps between bytes.
- sdCS falls in the first cycle of PRE, one cycle after accept. The first SCLK rise comes CLK_DIV cycles later.
- With R1 found on poll byte k (1 ≤ k ≤ RESP_TIMEOUT):
  - done asserts exactly 1 + (8+k)×16×CLK_DIV cycles after the accept cycle;
  - on timeout, k = RESP_TIMEOUT.
- r1 and timeout are valid no later than the done cycle.
- sdCS rises in the done cycle (hold_cs=0). sdSCLK is low whenever sdCS is high.
- Reset mid-command: on the next edge, all outputs take their reset values and the frame is abandoned. done does not pulse.

## Test plan
- CMD0: index 0, arg 0, CLK_DIV=4, sdsim returns 8'h01 on poll byte 2.
  - MOSI frame: FF 40 00 00 00 00 95, then FF FF, then trailer FF.
  - r1=8'h01, timeout=0.
  - done at accept+1+10×64 = 641 cycles; sdCS high in the done cycle.
- CMD8: arg 32'h000001AA.
  - MOSI frame bytes 48 00 00 01 AA 87.
  - R1 8'h01 on poll byte 1 gives done at accept+577.
- MISO stuck high, RESP_TIMEOUT=8:
  - exactly 8 poll bytes, then trailer;
  - r1=8'hFF, timeout=1, done at accept+1025.
- cmd_start pulsed repeatedly while busy:
  - no frame disturbance, a single done;
  - the next start after IDLE is accepted normally.
- hold_cs=1 command, then a second command with hold_cs=0:
  - sdCS stays low across both commands and rises only at the second done.
  - SCLK idles low between the two commands.
- Reset asserted during SEND byte 3:
  - next cycle: sdCS=1, sdSCLK=0, sdMOSI=1, busy=0, r1=FF, no done pulse;
  - a following CMD0 completes correctly.
